// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared fetch front-end constants, state encodings and PC helper
package ifetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic {IFQ_FETCH = 1'b0, IFQ_DROP = 1'b1} ifq_state_e;
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH x W synchronous FIFO with flush and a registered head that holds while empty
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] dout_q, dout_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && cnt_q != '0;
    do_push = push && (cnt_q != FULL || do_pop);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // the word being written becomes the head when it lands in the slot rd_d points at
    dout_d = (flush || cnt_d == '0) ? dout_q : (do_push && wr_q == rd_d) ? din : mem_q[rd_d];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      if (do_push && !flush) mem_q[wr_q] <= din;
    end
  assign dout = dout_q;
  assign count = cnt_q;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM, fetch PC and redirect squashing in front of the instruction FIFO
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic inst_valid,
  input  logic inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifq_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, addr_q;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0] cnt_d;
  logic req_q, req_d, push, pop;
  always_comb begin
    push = req_q && mem_ack && !redirect && state_q == IFQ_FETCH;
    pop = inst_valid && inst_ready;
    cnt_d = redirect ? '0 : q_count + CW'(push) - CW'(pop);
    mem_addr = state_q == IFQ_DROP ? addr_q : fetch_pc_q;
    fetch_pc_d = redirect ? redirect_pc : push ? pc_inc(fetch_pc_q) : fetch_pc_q;
    state_d = redirect ? ((req_q && !mem_ack) ? IFQ_DROP : IFQ_FETCH)
            : (state_q == IFQ_DROP && mem_ack) ? IFQ_FETCH : state_q;
    // an outstanding request is held; a new one is raised only if the queue will have room
    req_d = (req_q && !mem_ack) || cnt_d < CW'(DEPTH);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IFQ_FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= mem_addr;
      req_q <= req_d;
    end
  ifq_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din({mem_rdata, fetch_pc_q}),
    .dout(head),
    .count(q_count)
  );
  assign {inst, inst_pc} = head;
  assign mem_req = req_q;
  assign inst_valid = q_count != '0;
endmodule
